// File: rtl/iomem_pwm_gpio.sv
// iomem_pwm_gpio: memory-mapped GPIO register plus NUM_CH-channel PWM.
//
// Ports
//   clk, resetn      clock; synchronous active-low reset
//   iomem_valid      bus request
//   iomem_ready      one-cycle completion pulse, the cycle after a decoded hit
//   iomem_wstrb[3:0] byte write strobes (all zero = read)
//   iomem_addr[31:0] byte address; [31:24] must equal PAGE, [7:2] is the register offset
//   iomem_wdata[31:0] write data
//   iomem_rdata[31:0] read data, valid while iomem_ready=1 (0 otherwise)
//   gpio_out[31:0]   GPIO register contents
//   pwm_out[NUM_CH-1:0] registered PWM outputs
//
// Register offsets: 0 GPIO, 1 CTRL (bit0 EN, bit1 CLR self-clearing),
// 2 PRESC (16b), 3 CNT (RO), 4.. DUTY[i] (PWM_W bits).
//
// Build option: define PWM_SHADOW_EN to double-buffer DUTY writes; the active
// duty value then loads only at counter wrap or on CLR.

module iomem_pwm_gpio_ch #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
`ifdef PWM_SHADOW_EN
    input  logic             load,
`endif
    input  logic             wr,
    input  logic [PWM_W-1:0] wdata,
    input  logic [PWM_W-1:0] bmask,
    input  logic             en,
    input  logic [PWM_W-1:0] cnt,
    output logic [PWM_W-1:0] duty_rd,
    output logic             pwm
);
    logic [PWM_W-1:0] duty_act;
    logic [PWM_W-1:0] duty_nxt;

    assign duty_nxt = (duty_rd & ~bmask) | (wdata & bmask);

`ifdef PWM_SHADOW_EN
    logic [PWM_W-1:0] shadow;
    assign duty_rd = shadow;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow   <= '0;
            duty_act <= '0;
        end else begin
            if (wr)
                shadow <= duty_nxt;
            // a write landing on the wrap cycle is picked up by that same wrap
            if (load)
                duty_act <= wr ? duty_nxt : shadow;
        end
    end
`else
    logic [PWM_W-1:0] duty;
    assign duty_rd  = duty;
    assign duty_act = duty;

    always_ff @(posedge clk) begin
        if (!resetn)
            duty <= '0;
        else if (wr)
            duty <= duty_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn)
            pwm <= 1'b0;
        else
            pwm <= en && (cnt < duty_act);
    end
endmodule

module iomem_pwm_gpio #(
    parameter int          NUM_CH = 3,
    parameter int          PWM_W  = 8,
    parameter logic [7:0]  PAGE   = 8'h03
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic [31:0]       gpio_out,
    output logic [NUM_CH-1:0] pwm_out
);
    logic                          hit, wr, clr, tick;
    logic [5:0]                    offset;
    logic [31:0]                   bmask, gpio_nxt, rd_mux;
    logic [15:0]                   presc, presc_nxt, pc;
    logic                          en;
    logic [PWM_W-1:0]              cnt;
    logic [NUM_CH-1:0][PWM_W-1:0]  duty_rd;
    logic                          unused_addr;

    assign unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};

    // !iomem_ready blocks a second hit while the master still holds valid
    assign hit    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == PAGE);
    assign offset = iomem_addr[7:2];
    assign wr     = hit && (|iomem_wstrb);
    assign clr    = wr && (offset == 6'd1) && iomem_wstrb[0] && iomem_wdata[1];
    assign tick   = (pc == presc);

    assign bmask     = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign gpio_nxt  = (gpio_out & ~bmask) | (iomem_wdata & bmask);
    assign presc_nxt = (presc & ~bmask[15:0]) | (iomem_wdata[15:0] & bmask[15:0]);

`ifdef PWM_SHADOW_EN
    logic load;
    assign load = clr || (en && tick && (&cnt));
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [5:0] OFF = 6'(4 + i);
        iomem_pwm_gpio_ch #(.PWM_W(PWM_W)) u_ch (
            .clk     (clk),
            .resetn  (resetn),
`ifdef PWM_SHADOW_EN
            .load    (load),
`endif
            .wr      (wr && (offset == OFF)),
            .wdata   (iomem_wdata[PWM_W-1:0]),
            .bmask   (bmask[PWM_W-1:0]),
            .en      (en),
            .cnt     (cnt),
            .duty_rd (duty_rd[i]),
            .pwm     (pwm_out[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            6'd0:    rd_mux = gpio_out;
            6'd1:    rd_mux = {31'b0, en};
            6'd2:    rd_mux = {16'b0, presc};
            6'd3:    rd_mux = 32'(cnt);
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (offset == 6'(4 + i))
                        rd_mux = 32'(duty_rd[i]);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            gpio_out    <= '0;
            en          <= 1'b0;
            presc       <= '0;
            pc          <= '0;
            cnt         <= '0;
        end else begin
            iomem_ready <= hit;
            // rd_mux sees pre-write values, so reads return the old contents
            iomem_rdata <= hit ? rd_mux : '0;
            if (wr && offset == 6'd0)
                gpio_out <= gpio_nxt;
            if (wr && offset == 6'd1 && iomem_wstrb[0])
                en <= iomem_wdata[0];
            if (wr && offset == 6'd2)
                presc <= presc_nxt;
            if (clr) begin
                pc  <= '0;
                cnt <= '0;
            end else if (en) begin
                // pc above a freshly lowered PRESC free-runs to its 16-bit wrap
                pc <= tick ? 16'd0 : pc + 16'd1;
                if (tick)
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iomem_pwm_gpio.sv
module tb_iomem_pwm_gpio;
    localparam logic [31:0] A_GPIO  = 32'h0300_0000;
    localparam logic [31:0] A_CTRL  = 32'h0300_0004;
    localparam logic [31:0] A_PRESC = 32'h0300_0008;
    localparam logic [31:0] A_CNT   = 32'h0300_000C;
    localparam logic [31:0] A_DUTY0 = 32'h0300_0010;
    localparam logic [31:0] A_DUTY1 = 32'h0300_0014;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic [31:0] gpio_out;
    logic [2:0]  pwm_out;

    int checks = 0;
    int errors = 0;

    iomem_pwm_gpio #(.NUM_CH(3), .PWM_W(8), .PAGE(8'h03)) dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .gpio_out(gpio_out), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // one bus access; lat = cycles until ready (0 = none within 4 cycles)
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
        rd = '0; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (iomem_ready) begin
                rd = iomem_rdata; lat = i; break;
            end
        end
        iomem_valid = 1'b0; iomem_wstrb = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; int lat;
        bus(a, 4'b1111, d, rd, lat);
    endtask

    // cycles until next rising edge of pwm_out[ch], -1 if none within 600
    task automatic wait_rise(input int ch, output int n);
        logic prev;
        prev = pwm_out[ch];
        n = -1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (!prev && pwm_out[ch]) begin n = i; break; end
            prev = pwm_out[ch];
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", iomem_ready); end
        checks++; if (iomem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", iomem_rdata); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h want 0", gpio_out); end
        checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm got %b want 000", pwm_out); end
        resetn = 1'b1;
    endtask

    task automatic test_gpio;
        logic [31:0] rd; int lat;
        bus(A_GPIO, 4'b0101, 32'hA5A5_5A5A, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL gpio_wr_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL gpio_wr_readold got %h want 0", rd); end
        checks++; if (gpio_out !== 32'h00A5_005A) begin errors++; $display("FAIL gpio_strobe got %h want 00a5005a", gpio_out); end
        bus(A_GPIO, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h00A5_005A) begin errors++; $display("FAIL gpio_readback got %h want 00a5005a", rd); end
        bus(A_GPIO, 4'b1111, 32'h1234_5678, rd, lat);
        checks++; if (rd !== 32'h00A5_005A) begin errors++; $display("FAIL gpio_readold got %h want 00a5005a", rd); end
        checks++; if (gpio_out !== 32'h1234_5678) begin errors++; $display("FAIL gpio_full got %h want 12345678", gpio_out); end
        wr(A_CTRL, 32'hFFFF_FFFC);
        bus(A_CTRL, 4'b1110, 32'h0000_0001, rd, lat);
        bus(A_CTRL, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_mask got %h want 0", rd); end
        bus(A_PRESC, 4'b0110, 32'hABCD_1234, rd, lat);
        bus(A_PRESC, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_1200) begin errors++; $display("FAIL presc_strobe got %h want 00001200", rd); end
        wr(A_DUTY0, 32'hFFFF_FF80);
        bus(A_DUTY0, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL duty_width got %h want 00000080", rd); end
        wr(A_DUTY0, 32'h0);
    endtask

    task automatic test_pwm;
        int n, per, h0, h1, h2;
        logic prev;
        wr(A_PRESC, 32'd0);
        wr(A_DUTY0, 32'd64);
        wr(A_DUTY1, 32'd255);
        wr(A_CTRL, 32'h3);
        wait_rise(0, n);
        checks++; if (n < 0) begin errors++; $display("FAIL pwm_start got timeout want rising edge"); end
        h0 = 1; h1 = int'(pwm_out[1]); h2 = int'(pwm_out[2]); prev = 1'b1; per = -1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (!prev && pwm_out[0]) begin per = i; break; end
            h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
            prev = pwm_out[0];
        end
        checks++; if (per !== 256) begin errors++; $display("FAIL pwm_period got %0d want 256", per); end
        checks++; if (h0 !== 64) begin errors++; $display("FAIL pwm_duty64 got %0d want 64", h0); end
        checks++; if (h1 !== 255) begin errors++; $display("FAIL pwm_duty255 got %0d want 255", h1); end
        checks++; if (h2 !== 0) begin errors++; $display("FAIL pwm_duty0 got %0d want 0", h2); end
    endtask

    task automatic test_presc;
        logic [31:0] a, b; int lat;
        wr(A_PRESC, 32'd3);
        wr(A_CTRL, 32'h3);
        bus(A_CNT, 4'b0000, 32'h0, a, lat);
        repeat (6) @(negedge clk);
        bus(A_CNT, 4'b0000, 32'h0, b, lat);
        checks++; if (((b - a) & 32'hFF) !== 32'd2) begin errors++; $display("FAIL presc_rate got %0d want 2", (b - a) & 32'hFF); end
        wr(A_CTRL, 32'h0);
        bus(A_CNT, 4'b0000, 32'h0, a, lat);
        repeat (6) @(negedge clk);
        bus(A_CNT, 4'b0000, 32'h0, b, lat);
        checks++; if (b !== a) begin errors++; $display("FAIL cnt_frozen got %h want %h", b, a); end
        checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL pwm_disabled got %b want 000", pwm_out); end
    endtask

    task automatic test_duty_change;
        int n, h;
        wr(A_PRESC, 32'd0);
        wr(A_DUTY1, 32'd10);
        wr(A_CTRL, 32'h3);
        wait_rise(1, n);
        h = 0;
        for (int i = 0; i < 600 && pwm_out[1]; i++) begin h++; @(negedge clk); end
        checks++; if (h !== 10) begin errors++; $display("FAIL duty10_width got %0d want 10", h); end
        repeat (40) @(negedge clk);
        wr(A_DUTY1, 32'd200);
        @(negedge clk);
`ifdef PWM_SHADOW_EN
        checks++; if (pwm_out[1] !== 1'b0) begin errors++; $display("FAIL shadow_hold got %b want 0", pwm_out[1]); end
`else
        checks++; if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL duty_direct got %b want 1", pwm_out[1]); end
`endif
        wait_rise(1, n);
        h = 0;
        for (int i = 0; i < 600 && pwm_out[1]; i++) begin h++; @(negedge clk); end
        checks++; if (h !== 200) begin errors++; $display("FAIL duty200_width got %0d want 200", h); end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd; int lat;
        bus(32'h0300_00FC, 4'b0000, 32'h0, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL unmapped_ready got %0d want 1", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rdata got %h want 0", rd); end
        bus(32'h0300_00FC, 4'b1111, 32'hFFFF_FFFF, rd, lat);
        bus(32'h0400_0000, 4'b1111, 32'hDEAD_BEEF, rd, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL otherpage_ready got %0d want 0", lat); end
        bus(A_GPIO, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL otherpage_state got %h want 12345678", rd); end
    endtask

    task automatic test_reset_inflight;
        logic [31:0] rd; int lat;
        logic seen;
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = A_GPIO; iomem_wstrb = 4'b0000; resetn = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (iomem_ready) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL inflight_ready got %b want 0", seen); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL inflight_gpio got %h want 0", gpio_out); end
        checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL inflight_pwm got %b want 000", pwm_out); end
        checks++; if (iomem_rdata !== 32'h0) begin errors++; $display("FAIL inflight_rdata got %h want 0", iomem_rdata); end
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bus(A_GPIO, 4'b0000, 32'h0, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL post_reset_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_gpio got %h want 0", rd); end
        bus(A_DUTY1, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_duty got %h want 0", rd); end
        bus(A_PRESC, 4'b0000, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_presc got %h want 0", rd); end
    endtask

    initial begin
        test_reset;
        test_gpio;
        test_pwm;
        test_presc;
        test_duty_change;
        test_unmapped;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iomem_pwm_gpio.md
IOMEM_PWM_GPIO -- requirements
Module: iomem_pwm_gpio

Interface
REQ-001 Parameter NUM_CH, default 3, number of PWM channels (1..8).
REQ-002 Parameter PWM_W, default 8, PWM counter/duty width in bits (4..16).
REQ-003 Parameter PAGE, default 8'h03, value of iomem_addr[31:24] the block decodes.
REQ-004 clk  input  1  clock.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 iomem_valid  input  1  bus request.
REQ-007 iomem_ready  output  1  one-cycle completion pulse.
REQ-008 iomem_wstrb  input  4  byte write strobes; all zero means read.
REQ-009 iomem_addr  input  32  byte address.
REQ-010 iomem_wdata  input  32  write data.
REQ-011 iomem_rdata  output  32  read data, valid while iomem_ready=1.
REQ-012 gpio_out  output  32  GPIO register contents.
REQ-013 pwm_out  output  NUM_CH  PWM outputs; bit i is channel i.

Function
REQ-014 Decode: hit = iomem_valid && !iomem_ready && iomem_addr[31:24]==PAGE; offset = iomem_addr[7:2].
REQ-015 On hit, iomem_ready SHALL be 1 on the next cycle for exactly one cycle; there is no back-to-back ready; a non-hit leaves ready at 0.
REQ-016 Register map (offset): 0 GPIO (32b RW); 1 CTRL (bit0 EN, bit1 CLR, others read 0); 2 PRESC (16b RW); 3 CNT (RO, current PWM counter); 4..4+NUM_CH-1 DUTY[i] (PWM_W bits RW).
REQ-017 Writes honour each wstrb byte independently; bits beyond a register's width are ignored and read 0.
REQ-018 Reads return the register value before any same-access write (read-old); unmapped offsets read 0 and ignore writes but still produce ready.
REQ-019 Prescaler: counter pc counts 0..PRESC then resets to 0; tick is asserted in the cycle where pc==PRESC; PRESC=0 gives a tick every cycle.
REQ-020 PWM counter cnt (PWM_W bits) increments on tick while EN=1, wrapping from 2^PWM_W-1 to 0; wrap = tick && cnt==all-ones.
REQ-021 pc and cnt hold when EN=0; pwm_out SHALL be all zero when EN=0.
REQ-022 Writing CTRL with CLR=1 zeroes pc and cnt on the following cycle; CLR is self-clearing and reads 0.
REQ-023 pwm_out[i] = EN && (cnt < duty_act[i]), registered (one cycle after cnt); DUTY=0 gives constant 0; all-ones gives high for 2^PWM_W-1 of 2^PWM_W counts.
REQ-024 If a DUTY write coincides with a wrap, the new value takes effect at that wrap.
REQ-025 If a PRESC write lands mid-count with pc>new PRESC, pc continues to its 16-bit wrap; no lockup.

Reset
REQ-026 While resetn=0: GPIO, CTRL, PRESC, all DUTY, shadows, pc, cnt, iomem_ready, iomem_rdata, and pwm_out are 0; any access in flight is dropped without ready.
REQ-027 The first hit after resetn rises is serviced normally with single-cycle latency.

Configuration
REQ-028 Macro PWM_SHADOW_EN, when defined: DUTY writes go to a shadow register; duty_act[i] loads from the shadow at wrap and on CLR; reads of DUTY return the shadow.
REQ-029 Without PWM_SHADOW_EN: duty_act[i] equals the DUTY register and updates the cycle after the write (glitches permitted).

Verification
REQ-030 Write 0x03000000=0xA5A5_5A5A with wstrb=4'b0101 -> next cycle ready=1; gpio_out=0x00A5_005A; readback matches.
REQ-031 PRESC=0, DUTY[0]=64, EN=1, PWM_W=8 -> pwm_out[0] high 64 of every 256 cycles, period exactly 256.
REQ-032 PRESC=3 -> CNT advances once per 4 cycles; write EN=0 -> CNT frozen and pwm_out=0.
REQ-033 With PWM_SHADOW_EN, DUTY[1] changed 10->200 mid-period -> output stays at 10 until wrap, then 200; without the macro it changes within 2 cycles.
REQ-034 Read offset 0x3F and access PAGE+1 -> the first returns 0 with ready; the second gets no ready and changes no state.
REQ-035 resetn pulsed low during a pending hit -> no ready, all outputs 0; the post-reset GPIO read returns 0.
